// File: rtl/para_ustu_ctrl.sv
// Change-return controller for a two-hopper (10-unit / 5-unit) coin dispenser.
// A request is judged feasible once, then coins are ejected one at a time under a hop_ack handshake.
module para_ustu_ctrl #(
    parameter int unsigned INIT_CNT = 8,
    parameter int unsigned TIMEOUT  = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] amount,
    input  logic       hop_ack,
    input  logic       refill10,
    input  logic       refill5,
    output logic       hop10_go,
    output logic       hop5_go,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] cnt10,
    output logic [3:0] cnt5
);

    localparam logic [3:0] INIT_VAL = 4'(INIT_CNT);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_DISP10 = 3'd2,
        S_DISP5  = 3'd3,
        S_GAP    = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t     state_r;
    state_t     state_nx;
    state_t     next_coin_s;
    logic [5:0] rem_r;
    logic [5:0] rem_nx;
    logic [7:0] timer_r;
    logic [7:0] timer_nx;
    logic [3:0] cnt10_r;
    logic [3:0] cnt10_nx;
    logic [3:0] cnt5_r;
    logic [3:0] cnt5_nx;
    logic       dec10_s;
    logic       dec5_s;
    logic       go10_r;
    logic       go5_r;
    logic       busy_r;
    logic       done_r;
    logic       err_r;

    function automatic logic [2:0] tens_of(input logic [5:0] v);
        logic [2:0] q;
        if (v >= 6'd60)      q = 3'd6;
        else if (v >= 6'd50) q = 3'd5;
        else if (v >= 6'd40) q = 3'd4;
        else if (v >= 6'd30) q = 3'd3;
        else if (v >= 6'd20) q = 3'd2;
        else if (v >= 6'd10) q = 3'd1;
        else                 q = 3'd0;
        return q;
    endfunction

    function automatic logic is_mult5(input logic [5:0] v);
        return ((v % 6'd5) == 6'd0);
    endfunction

    // Greedy use of 10s limited by stock; the remainder must fit in the 5-unit stock.
    function automatic logic feasible(input logic [5:0] v, input logic [3:0] c10,
                                      input logic [3:0] c5);
        logic [2:0] n10;
        logic [7:0] left;
        logic [7:0] cap;
        n10  = tens_of(v);
        n10  = ({1'b0, n10} > c10) ? c10[2:0] : n10;
        left = {2'b00, v} - (8'(n10) * 8'd10);
        cap  = {2'b00, c5, 2'b00} + {4'b0000, c5};
        return (left <= cap);
    endfunction

    function automatic logic [3:0] cnt_update(input logic [3:0] c, input logic inc,
                                              input logic dec);
        logic [3:0] r;
        if (inc && !dec)      r = (c == 4'd15) ? 4'd15 : c + 4'd1;
        else if (dec && !inc) r = (c == 4'd0) ? 4'd0 : c - 4'd1;
        else                  r = c;
        return r;
    endfunction

    // Choice of the next coin (or completion) from the remaining amount and 10-unit stock.
    always_comb begin
        next_coin_s = S_DISP5;
        if (rem_r == 6'd0) begin
            next_coin_s = S_DONE;
        end else if ((rem_r >= 6'd10) && (cnt10_r != 4'd0)) begin
            next_coin_s = S_DISP10;
        end else begin
            next_coin_s = S_DISP5;
        end
    end

    // Next-state, remaining-amount, per-coin timer and decrement strobes.
    always_comb begin
        state_nx = state_r;
        rem_nx   = rem_r;
        timer_nx = timer_r;
        dec10_s  = 1'b0;
        dec5_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    rem_nx   = amount;
                    state_nx = S_CHECK;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_CHECK: begin
                if (!is_mult5(rem_r) || (rem_r > 6'd55) || !feasible(rem_r, cnt10_r, cnt5_r)) begin
                    state_nx = S_ERR;
                    rem_nx   = 6'd0;
                end else begin
                    state_nx = next_coin_s;
                    timer_nx = 8'd0;
                end
            end
            S_DISP10, S_DISP5: begin
                if (hop_ack) begin
                    state_nx = S_GAP;
                    if (state_r == S_DISP10) begin
                        rem_nx  = rem_r - 6'd10;
                        dec10_s = 1'b1;
                    end else begin
                        rem_nx = rem_r - 6'd5;
                        dec5_s = 1'b1;
                    end
                end else if (timer_r >= TMO_LAST) begin
                    state_nx = S_ERR;
                    rem_nx   = 6'd0;
                end else begin
                    timer_nx = timer_r + 8'd1;
                end
            end
            S_GAP: begin
                state_nx = next_coin_s;
                timer_nx = 8'd0;
            end
            S_DONE, S_ERR: begin
                state_nx = S_IDLE;
                rem_nx   = 6'd0;
                timer_nx = 8'd0;
            end
            default: begin
                state_nx = S_IDLE;
                rem_nx   = 6'd0;
                timer_nx = 8'd0;
            end
        endcase
    end

    // Inventory next values: refill and eject in the same cycle cancel out.
    always_comb begin
        cnt10_nx = cnt_update(cnt10_r, refill10, dec10_s);
        cnt5_nx  = cnt_update(cnt5_r, refill5, dec5_s);
    end

    // Controller state, amount and timer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
            rem_r   <= 6'd0;
            timer_r <= 8'd0;
        end else begin
            state_r <= state_nx;
            rem_r   <= rem_nx;
            timer_r <= timer_nx;
        end
    end

    // Hopper inventory registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt10_r <= INIT_VAL;
            cnt5_r  <= INIT_VAL;
        end else begin
            cnt10_r <= cnt10_nx;
            cnt5_r  <= cnt5_nx;
        end
    end

    // Outputs are registered decodes of the state being entered, so they align with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            go10_r <= 1'b0;
            go5_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            go10_r <= (state_nx == S_DISP10);
            go5_r  <= (state_nx == S_DISP5);
            busy_r <= (state_nx != S_IDLE);
            done_r <= (state_nx == S_DONE);
            err_r  <= (state_nx == S_ERR);
        end
    end

    assign hop10_go = go10_r;
    assign hop5_go  = go5_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;
    assign cnt10    = cnt10_r;
    assign cnt5     = cnt5_r;

endmodule

// File: tb/tb_para_ustu_ctrl.sv
// Self-checking bench for para_ustu_ctrl: table of change requests with a result
// scoreboard, plus hand-written sequences for timeout, refill saturation and reset abort.
module tb_para_ustu_ctrl;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       start     = 1'b0;
    logic [5:0] amount    = 6'd0;
    logic       refill10  = 1'b0;
    logic       refill5   = 1'b0;
    logic       ack_force = 1'b0;
    logic       ack_resp  = 1'b0;
    logic       hop_ack;
    logic       hop10_go;
    logic       hop5_go;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] cnt10;
    logic [3:0] cnt5;

    bit ack_en   = 1'b1;
    int ack_dly  = 0;
    int wait_cnt = 0;
    int checks   = 0;
    int passes   = 0;

    typedef struct {
        logic [5:0] amount;
        int         dly;
        int         exp_done;
        int         n10;
        int         n5;
        int         c10;
        int         c5;
    } vec_t;

    vec_t vecs[9];
    vec_t sb[$];

    assign hop_ack = ack_force | ack_resp;

    always #5 clk = ~clk;

    para_ustu_ctrl #(.INIT_CNT(8), .TIMEOUT(10)) dut (
        .clk(clk), .rst(rst), .start(start), .amount(amount), .hop_ack(hop_ack),
        .refill10(refill10), .refill5(refill5), .hop10_go(hop10_go), .hop5_go(hop5_go),
        .busy(busy), .done(done), .err(err), .cnt10(cnt10), .cnt5(cnt5)
    );

    // Hopper model: acknowledges a held go after ack_dly sampling cycles.
    always @(negedge clk) begin
        if ((hop10_go || hop5_go) && ack_en && rst) begin
            if (wait_cnt >= ack_dly) begin
                ack_resp = 1'b1;
                wait_cnt = 0;
            end else begin
                ack_resp = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            ack_resp = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        int   n10 = 0;
        int   n5 = 0;
        int   first = 0;
        int   lat = 0;
        bit   fin = 1'b0;
        bit   both = 1'b0;
        logic p10 = 1'b0;
        logic p5 = 1'b0;
        ack_en  = 1'b1;
        ack_dly = v.dly;
        @(negedge clk);
        start  = 1'b1;
        amount = v.amount;
        sb.push_back(v);
        for (int k = 1; k <= 400 && !fin; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (hop10_go && !p10) begin n10++; if (first == 0) first = k; end
            if (hop5_go && !p5) begin n5++; if (first == 0) first = k; end
            if (hop10_go && hop5_go) both = 1'b1;
            p10 = hop10_go;
            p5  = hop5_go;
            if (done || err) begin
                fin = 1'b1;
                lat = k;
            end
        end
        e = sb.pop_front();
        check($sformatf("finish_%0d", e.amount), int'(fin), 1);
        if (fin) begin
            check($sformatf("done_%0d", e.amount), int'(done), e.exp_done);
            check($sformatf("err_%0d", e.amount), int'(err), 1 - e.exp_done);
            check($sformatf("n10_%0d", e.amount), n10, e.n10);
            check($sformatf("n5_%0d", e.amount), n5, e.n5);
            check($sformatf("cnt10_%0d", e.amount), int'(cnt10), e.c10);
            check($sformatf("cnt5_%0d", e.amount), int'(cnt5), e.c5);
            check($sformatf("both_go_%0d", e.amount), int'(both), 0);
            if (e.n10 + e.n5 == 0) check($sformatf("latency_%0d", e.amount), lat, 2);
            else                   check($sformatf("first_go_%0d", e.amount), first, 2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   go_cyc;
        bit   seen_err;
        bit   seen_done;
        bit   found;
        bit   bad;
        logic err_go;

        // amount, ack delay, done?, #10 coins, #5 coins, cnt10 after, cnt5 after
        vecs[0] = '{6'd35, 3, 1, 3, 1, 5, 7};
        vecs[1] = '{6'd12, 0, 0, 0, 0, 5, 7};
        vecs[2] = '{6'd60, 0, 0, 0, 0, 5, 7};
        vecs[3] = '{6'd55, 1, 1, 5, 1, 0, 6};
        vecs[4] = '{6'd15, 0, 1, 0, 3, 0, 3};
        vecs[5] = '{6'd20, 2, 0, 0, 0, 0, 3};
        vecs[6] = '{6'd15, 0, 1, 0, 3, 0, 0};
        vecs[7] = '{6'd5,  0, 0, 0, 0, 0, 0};
        vecs[8] = '{6'd0,  0, 1, 0, 0, 0, 0};

        repeat (3) @(negedge clk);
        check("rst_go10", int'(hop10_go), 0);
        check("rst_go5", int'(hop5_go), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_cnt10", int'(cnt10), 8);
        check("rst_cnt5", int'(cnt5), 8);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        @(negedge clk);
        refill10 = 1'b1;
        repeat (2) @(negedge clk);
        refill10 = 1'b0;
        check("refill10_cnt", int'(cnt10), 2);
        run_vec('{6'd25, 0, 0, 0, 0, 2, 0});

        // hop_ack while idle must not touch anything
        @(negedge clk);
        ack_force = 1'b1;
        repeat (2) @(negedge clk);
        ack_force = 1'b0;
        check("idle_ack_busy", int'(busy), 0);
        check("idle_ack_go", int'(hop10_go | hop5_go), 0);
        check("idle_ack_cnt10", int'(cnt10), 2);
        check("idle_ack_cnt5", int'(cnt5), 0);

        // Timeout with a start pulse injected mid-dispense (must be ignored)
        ack_en = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        amount = 6'd10;
        @(negedge clk);
        start     = 1'b0;
        go_cyc    = 0;
        seen_err  = 1'b0;
        seen_done = 1'b0;
        err_go    = 1'b1;
        for (int k = 0; k < 60 && !seen_err; k++) begin
            @(negedge clk);
            if (k == 3) begin start = 1'b1; amount = 6'd0; end
            else        start = 1'b0;
            if (hop10_go) go_cyc++;
            if (done) seen_done = 1'b1;
            if (err) begin seen_err = 1'b1; err_go = hop10_go; end
        end
        start = 1'b0;
        check("tmo_err_seen", int'(seen_err), 1);
        check("tmo_go_cycles", go_cyc, 10);
        check("tmo_go_low_at_err", int'(err_go), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("tmo_no_done", int'(seen_done), 0);
        check("tmo_busy", int'(busy), 0);
        check("tmo_cnt10", int'(cnt10), 2);

        // 5-unit refill saturation, and refill coinciding with an ejected 5
        @(negedge clk);
        refill5 = 1'b1;
        repeat (17) @(negedge clk);
        refill5 = 1'b0;
        check("sat_cnt5", int'(cnt5), 15);
        start  = 1'b1;
        amount = 6'd5;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (hop5_go) found = 1'b1;
        end
        check("sat_go5_seen", int'(found), 1);
        ack_force = 1'b1;
        refill5   = 1'b1;
        @(negedge clk);
        ack_force = 1'b0;
        refill5   = 1'b0;
        check("sat_ack_refill_cnt5", int'(cnt5), 15);
        check("sat_go5_dropped", int'(hop5_go), 0);
        seen_done = 1'b0;
        for (int k = 0; k < 5 && !seen_done; k++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("sat_done", int'(seen_done), 1);
        @(negedge clk);
        refill5 = 1'b1;
        @(negedge clk);
        refill5 = 1'b0;
        check("sat_refill_alone", int'(cnt5), 15);
        check("sat_cnt10", int'(cnt10), 2);

        // Asynchronous reset while hop5_go is held
        @(negedge clk);
        start  = 1'b1;
        amount = 6'd5;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (hop5_go) found = 1'b1;
        end
        check("arst_go5_seen", int'(found), 1);
        #2 rst = 1'b0;
        #1;
        check("arst_go5", int'(hop5_go), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_cnt10", int'(cnt10), 8);
        check("arst_cnt5", int'(cnt5), 8);
        check("arst_err", int'(err), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (hop10_go || hop5_go || done || err || busy) bad = 1'b1;
        end
        check("arst_quiet_after", int'(bad), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/para_ustu_ctrl.md
PARA_USTU_CTRL -- requirements
Module: para_ustu_ctrl

Interface
REQ-001 SHALL provide parameter INIT_CNT, default 8: coin count loaded into each hopper inventory at reset (0..15).
REQ-002 SHALL provide parameter TIMEOUT, default 200: maximum cycles to wait for hop_ack per coin (1..255).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  in  1  system clock, rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle request to return change.
REQ-007 SHALL have port amount  in  6  change value in currency units, 0..55, sampled with start.
REQ-008 SHALL have port hop_ack  in  1  hopper confirms one coin ejected.
REQ-009 SHALL have port refill10  in  1  add one 10-unit coin to inventory.
REQ-010 SHALL have port refill5  in  1  add one 5-unit coin to inventory.
REQ-011 SHALL have port hop10_go  out  1  eject request to 10-unit hopper.
REQ-012 SHALL have port hop5_go  out  1  eject request to 5-unit hopper.
REQ-013 SHALL have port busy  out  1  high from the cycle after accepted start until done/err.
REQ-014 SHALL have port done  out  1  one-cycle pulse, change fully returned.
REQ-015 SHALL have port err  out  1  one-cycle pulse, request rejected or aborted.
REQ-016 SHALL have port cnt10, cnt5  out  4 each  current inventory counts.

Function
REQ-017 SHALL implement states IDLE, CHECK, DISP10, DISP5, GAP, DONE, ERR; all outputs registered.
REQ-018 IDLE: start=1 latches amount into rem, goes to CHECK; start in any other state is ignored.
REQ-019 CHECK (1 cycle): ERR if amount not multiple of 5 or >55; else n10=min(rem/10,cnt10); ERR if rem-10*n10 > 5*cnt5; else DONE if rem=0, DISP10 if rem>=10 and cnt10>0, else DISP5.
REQ-020 Feasibility is checked once in CHECK; no coin is ejected for a rejected request.
REQ-021 DISP10/DISP5: corresponding go held high until hop_ack sampled high; never both go high.
REQ-022 On hop_ack in DISPx: rem -= 10 or 5, matching count decrements, go drops next cycle, state -> GAP.
REQ-023 GAP (1 cycle, go low): DONE if rem=0; DISP10 if rem>=10 and cnt10>0; else DISP5.
REQ-024 Per-coin timer reloads on DISPx entry; if TIMEOUT cycles pass without hop_ack -> ERR, go drops, rem discarded.
REQ-025 hop_ack outside DISPx SHALL be ignored.
REQ-026 DONE and ERR each last 1 cycle, pulse their output, return to IDLE; busy low in IDLE only.
REQ-027 Latency: start to first go = 2 cycles; per coin = ack latency + 2 cycles.
REQ-028 refill10/refill5 accepted in any state; saturate at 15.
REQ-029 Refill and decrement of the same count in one cycle SHALL leave count unchanged.
REQ-030 Refills arriving during dispense do not change the feasibility decision already made.

Reset
REQ-031 rst low SHALL immediately force IDLE, all go/busy/done/err low, rem=0, timer=0, cnt10=cnt5=INIT_CNT.
REQ-032 Reset mid-dispense aborts without err pulse; no go asserted until a new start after release.

Verification
REQ-033 Reset, amount=35, acks 3 cycles after each go -> three hop10_go pulses, one hop5_go, done once, cnt10=5, cnt5=7.
REQ-034 cnt10=0, cnt5=3, amount=20 -> err pulse 1 cycle after CHECK, no go, counts unchanged.
REQ-035 amount=12 -> err, no go; amount=0 -> done 2 cycles after start, no go.
REQ-036 TIMEOUT=10, amount=10, hop_ack never -> hop10_go high 10 cycles, then err, busy low, cnt10 unchanged.
REQ-037 cnt5=15, refill5 with 5-coin ack in same cycle -> cnt5 stays 15; refill5 alone at 15 -> stays 15.
REQ-038 rst low while hop5_go high -> go, busy low asynchronously, counts=INIT_CNT, no done/err.
